// File: rtl/led_frame_serializer_pkg.sv
// Shared definitions for the LED frame serializer: state encoding, frame
// geometry and the parity helper.
package led_frame_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    GAP  = 2'b10
  } ser_state_t;

  localparam logic [3:0] DEFAULT_PREAMBLE = 4'b1010;

  function automatic int frame_width(input int pre_len, input int addr_w, input int data_w);
    return pre_len + addr_w + data_w + 1;
  endfunction

  // Even parity: the appended bit makes the total count of ones even.
  function automatic logic even_parity(input logic [63:0] payload);
    return ^payload;
  endfunction

endpackage

// File: rtl/led_frame_serializer_bit_timer.sv
// Free-running period timer: counts 0..COUNT-1 while enabled and strobes
// bit_end on the last count; clear holds it at zero.
module led_bit_timer
  import led_frame_serializer_pkg::*;
#(
  parameter int COUNT = 2
) (
  input  logic DIV8_CLK,
  input  logic globalReset,
  input  logic clear,
  input  logic enable,
  output logic bit_end
);

  localparam int W = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [W-1:0] LAST = W'(COUNT - 1);

  logic [W-1:0] tmr;

  always_ff @(posedge DIV8_CLK or posedge globalReset) begin
    if (globalReset) begin
      tmr <= '0;
    end else if (clear) begin
      tmr <= '0;
    end else if (enable) begin
      tmr <= (tmr == LAST) ? '0 : tmr + 1'b1;
    end
  end

  assign bit_end = enable && (tmr == LAST);

endmodule

// File: rtl/led_frame_serializer.sv
// Frames a parallel LED command as {preamble, address, data, parity} and
// shifts it out MSB first, toggling balanceCLK once per transmitted bit.
module led_frame_serializer
  import led_frame_serializer_pkg::*;
#(
  parameter int                  ADDR_W     = 4,
  parameter int                  DATA_W     = 8,
  parameter int                  PRE_LEN    = 4,
  parameter logic [PRE_LEN-1:0]  PREAMBLE   = PRE_LEN'(DEFAULT_PREAMBLE),
  parameter int                  BIT_CYCLES = 2,
  parameter int                  GAP_BITS   = 2
) (
  input  logic              DIV8_CLK,
  input  logic              globalReset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  output logic              reData,
  output logic              balanceCLK,
  output logic              busy,
  output logic              frame_done
);

  localparam int FRAME_W = frame_width(PRE_LEN, ADDR_W, DATA_W);
  localparam int CNT_W   = $clog2(FRAME_W);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_W - 1);

  ser_state_t         state_q, state_d;
  logic [FRAME_W-1:0] shift_q;
  logic [FRAME_W-1:0] frame_word;
  logic [CNT_W-1:0]   bit_cnt;
  logic               accept, shift_bit, finish;
  logic               bit_end, gap_end;
  logic               in_send, in_gap;

  assign in_send = (state_q == SEND);
  assign in_gap  = (state_q == GAP);
  assign busy    = (state_q != IDLE);

  assign frame_word = {PREAMBLE, in_addr, in_data,
                       even_parity(64'({in_addr, in_data}))};

  led_bit_timer #(.COUNT(BIT_CYCLES)) u_bit_timer (
    .DIV8_CLK    (DIV8_CLK),
    .globalReset (globalReset),
    .clear       (!in_send),
    .enable      (in_send),
    .bit_end     (bit_end)
  );

  led_bit_timer #(.COUNT(GAP_BITS * BIT_CYCLES)) u_gap_timer (
    .DIV8_CLK    (DIV8_CLK),
    .globalReset (globalReset),
    .clear       (!in_gap),
    .enable      (in_gap),
    .bit_end     (gap_end)
  );

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    shift_bit = 1'b0;
    finish    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          accept  = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (bit_end) begin
          if (bit_cnt != '0) begin
            shift_bit = 1'b1;
          end else begin
            finish  = 1'b1;
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (gap_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge DIV8_CLK or posedge globalReset) begin
    if (globalReset) state_q <= IDLE;
    else             state_q <= state_d;
  end

  // reData always presents shift_q's MSB; the next bit is already one below it.
  always_ff @(posedge DIV8_CLK or posedge globalReset) begin
    if (globalReset) begin
      shift_q    <= '0;
      bit_cnt    <= '0;
      reData     <= 1'b0;
      balanceCLK <= 1'b0;
      in_ready   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      in_ready   <= (state_d == IDLE);
      frame_done <= finish;
      if (accept) begin
        shift_q    <= frame_word;
        bit_cnt    <= LAST_IDX;
        reData     <= frame_word[FRAME_W-1];
        balanceCLK <= ~balanceCLK;
      end else if (shift_bit) begin
        shift_q    <= shift_q << 1;
        bit_cnt    <= bit_cnt - 1'b1;
        reData     <= shift_q[FRAME_W-2];
        balanceCLK <= ~balanceCLK;
      end else if (finish) begin
        reData     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_led_frame_serializer.sv
// Directed bench for led_frame_serializer: each scenario task drives a
// command, records one frame window and compares it with hand-built frames.
module tb_led_frame_serializer;

  logic       DIV8_CLK = 1'b0;
  logic       globalReset = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] in_addr = 4'h0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, reData, balanceCLK, busy, frame_done;

  int checks = 0;
  int failures = 0;

  // One window = the 39 negedge samples following an accept edge.
  logic s_re[0:38], s_bal[0:38], s_done[0:38], s_rdy[0:38], s_busy[0:38];
  logic bal_before;

  led_frame_serializer dut (
    .DIV8_CLK    (DIV8_CLK),
    .globalReset (globalReset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_addr     (in_addr),
    .in_data     (in_data),
    .reData      (reData),
    .balanceCLK  (balanceCLK),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #5 DIV8_CLK = ~DIV8_CLK;

  // Called on a negedge; returns just after the accepting posedge.
  task automatic send_cmd(input logic [3:0] a, input logic [7:0] d, output int waited);
    waited = 0;
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    while (!in_ready && waited < 100) begin
      @(negedge DIV8_CLK);
      waited++;
    end
    checks++;
    if (!in_ready) begin
      failures++;
      $display("[TB] FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, waited);
    end
    bal_before = balanceCLK;
    @(posedge DIV8_CLK);
  endtask

  task automatic collect(input bit drop_valid, input int change_at, input logic [3:0] new_addr,
                         input logic [7:0] new_data, input int abort_at);
    for (int k = 0; k < 39; k++) begin
      @(negedge DIV8_CLK);
      if (k == 0 && drop_valid) in_valid = 1'b0;
      if (k == change_at) begin
        in_addr = new_addr;
        in_data = new_data;
      end
      if (k == abort_at) begin
        globalReset = 1'b1;
        #1;
        break;
      end
      s_re[k]   = reData;
      s_bal[k]  = balanceCLK;
      s_done[k] = frame_done;
      s_rdy[k]  = in_ready;
      s_busy[k] = busy;
    end
  endtask

  function automatic logic [16:0] decode_frame(output int hold_err);
    logic [16:0] f;
    hold_err = 0;
    for (int i = 0; i < 17; i++) begin
      f[16-i] = s_re[2*i];
      if (s_re[2*i+1] !== s_re[2*i]) hold_err++;
    end
    return f;
  endfunction

  function automatic int count_toggles();
    int t = 0;
    logic prev = bal_before;
    for (int k = 0; k < 39; k++) begin
      if (s_bal[k] !== prev) t++;
      prev = s_bal[k];
    end
    return t;
  endfunction

  function automatic int first_high(input int which);
    for (int k = 0; k < 39; k++) begin
      if (which == 0 && s_done[k] === 1'b1) return k;
      if (which == 1 && s_rdy[k] === 1'b1) return k;
    end
    return -1;
  endfunction

  task automatic test_reset();
    #2;
    checks++; if (reData !== 1'b0) begin failures++; $display("[TB] FAIL reset_reData: got %b want 0", reData); end
    checks++; if (balanceCLK !== 1'b0) begin failures++; $display("[TB] FAIL reset_balanceCLK: got %b want 0", balanceCLK); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("[TB] FAIL reset_frame_done: got %b want 0", frame_done); end
    @(negedge DIV8_CLK);
    @(negedge DIV8_CLK);
    globalReset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL ready_before_edge: got %b want 0", in_ready); end
    @(posedge DIV8_CLK);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL ready_after_edge: got %b want 1", in_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_basic_frame();
    int w, herr, tog, nbusy, nzero, ndone;
    logic [16:0] f;
    @(negedge DIV8_CLK);
    send_cmd(4'h3, 8'hA5, w);
    collect(1'b1, -1, 4'h0, 8'h00, -1);
    f = decode_frame(herr);
    tog = count_toggles();
    nbusy = 0; nzero = 0; ndone = 0;
    for (int k = 0; k < 38; k++) if (s_busy[k] === 1'b1) nbusy++;
    for (int k = 34; k < 39; k++) if (s_re[k] === 1'b0) nzero++;
    for (int k = 0; k < 39; k++) if (s_done[k] === 1'b1) ndone++;
    checks++; if (f !== 17'b1010_0011_10100101_0) begin failures++; $display("[TB] FAIL basic_frame: got %b want %b", f, 17'b1010_0011_10100101_0); end
    checks++; if (herr !== 0) begin failures++; $display("[TB] FAIL basic_hold: got %0d unheld bits want 0", herr); end
    checks++; if (tog !== 17) begin failures++; $display("[TB] FAIL basic_toggles: got %0d want 17", tog); end
    checks++; if (first_high(0) !== 34) begin failures++; $display("[TB] FAIL basic_done_time: got %0d want 34", first_high(0)); end
    checks++; if (ndone !== 1) begin failures++; $display("[TB] FAIL basic_done_width: got %0d want 1", ndone); end
    checks++; if (first_high(1) !== 38) begin failures++; $display("[TB] FAIL basic_ready_time: got %0d want 38", first_high(1)); end
    checks++; if (nbusy !== 38 || s_busy[38] !== 1'b0) begin failures++; $display("[TB] FAIL basic_busy: got %0d busy cycles, last=%b want 38, 0", nbusy, s_busy[38]); end
    checks++; if (nzero !== 5) begin failures++; $display("[TB] FAIL basic_gap_reData: got %0d zero samples want 5", nzero); end
  endtask

  task automatic test_parity_one();
    int w, herr;
    logic [16:0] f;
    send_cmd(4'h1, 8'h00, w);
    collect(1'b1, -1, 4'h0, 8'h00, -1);
    f = decode_frame(herr);
    checks++; if (f !== 17'b1010_0001_00000000_1) begin failures++; $display("[TB] FAIL parity_frame: got %b want %b", f, 17'b1010_0001_00000000_1); end
    checks++; if (s_re[32] !== 1'b1 || s_re[33] !== 1'b1) begin failures++; $display("[TB] FAIL parity_bit: got %b%b want 11", s_re[32], s_re[33]); end
    checks++; if (s_re[34] !== 1'b0) begin failures++; $display("[TB] FAIL parity_after: got %b want 0", s_re[34]); end
  endtask

  task automatic test_back_to_back();
    int w, herr, nrdy, nchg;
    logic [16:0] f;
    send_cmd(4'h5, 8'h96, w);
    collect(1'b0, 1, 4'hE, 8'h81, -1);
    f = decode_frame(herr);
    nrdy = 0; nchg = 0;
    for (int k = 0; k < 38; k++) if (s_rdy[k] !== 1'b0) nrdy++;
    for (int k = 33; k < 39; k++) if (s_bal[k] !== s_bal[32]) nchg++;
    checks++; if (f !== 17'b1010_0101_10010110_0) begin failures++; $display("[TB] FAIL b2b_frame1: got %b want %b", f, 17'b1010_0101_10010110_0); end
    checks++; if (nrdy !== 0) begin failures++; $display("[TB] FAIL b2b_ready_busy: got %0d ready samples want 0", nrdy); end
    checks++; if (nchg !== 0) begin failures++; $display("[TB] FAIL b2b_gap_static: got %0d balanceCLK changes want 0", nchg); end
    send_cmd(4'hE, 8'h81, w);
    checks++; if (w !== 0) begin failures++; $display("[TB] FAIL b2b_spacing: got %0d extra cycles want 0", w); end
    collect(1'b1, -1, 4'h0, 8'h00, -1);
    f = decode_frame(herr);
    checks++; if (f !== 17'b1010_1110_10000001_1) begin failures++; $display("[TB] FAIL b2b_frame2: got %b want %b", f, 17'b1010_1110_10000001_1); end
    checks++; if (count_toggles() !== 17) begin failures++; $display("[TB] FAIL b2b_toggles: got %0d want 17", count_toggles()); end
  endtask

  task automatic test_capture();
    int w, herr;
    logic [16:0] f;
    send_cmd(4'hC, 8'h3C, w);
    collect(1'b1, 3, 4'hC, 8'hFF, -1);
    f = decode_frame(herr);
    checks++; if (f !== 17'b1010_1100_00111100_0) begin failures++; $display("[TB] FAIL capture_frame: got %b want %b", f, 17'b1010_1100_00111100_0); end
    checks++; if (herr !== 0) begin failures++; $display("[TB] FAIL capture_hold: got %0d want 0", herr); end
  endtask

  task automatic test_reset_abort();
    int w, herr, ndone;
    logic [16:0] f;
    send_cmd(4'h3, 8'hA5, w);
    collect(1'b1, -1, 4'h0, 8'h00, 18);
    checks++; if (reData !== 1'b0) begin failures++; $display("[TB] FAIL abort_reData: got %b want 0", reData); end
    checks++; if (balanceCLK !== 1'b0) begin failures++; $display("[TB] FAIL abort_balanceCLK: got %b want 0", balanceCLK); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL abort_busy: got %b want 0", busy); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL abort_in_ready: got %b want 0", in_ready); end
    ndone = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge DIV8_CLK);
      if (frame_done !== 1'b0) ndone++;
    end
    globalReset = 1'b0;
    @(negedge DIV8_CLK);
    for (int k = 0; k < 4; k++) begin
      if (frame_done !== 1'b0) ndone++;
      @(negedge DIV8_CLK);
    end
    checks++; if (ndone !== 0) begin failures++; $display("[TB] FAIL abort_no_done: got %0d pulses want 0", ndone); end
    send_cmd(4'h1, 8'h00, w);
    collect(1'b1, -1, 4'h0, 8'h00, -1);
    f = decode_frame(herr);
    checks++; if (f !== 17'b1010_0001_00000000_1) begin failures++; $display("[TB] FAIL abort_new_frame: got %b want %b", f, 17'b1010_0001_00000000_1); end
    checks++; if (count_toggles() !== 17) begin failures++; $display("[TB] FAIL abort_toggles: got %0d want 17", count_toggles()); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_parity_one();
    test_back_to_back();
    test_capture();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
